// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and sizing constants for the multiply/divide unit.
package mdu_pkg;
  typedef enum logic [1:0] {MDU_MUL, MDU_UDIV, MDU_SDIV, MDU_UREM} mdu_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_t;
  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 5;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: one restoring-division step, shifting the next dividend bit into the remainder.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] sh, diff;
  always_comb begin
    sh = {rem_i, bit_i};
    diff = sh - {1'b0, divisor_i};
    q_o = !diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiply / restoring divide, one bit per cycle.
// Define MDU_REM_EN to make op=11 an unsigned remainder; otherwise it completes with no write.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  we_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [WIDTH-1:0]      result
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_t state_q, state_d;
  mdu_op_t op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic neg_q, neg_d, done_q, done_d, we_q, we_d;
  logic [WIDTH-1:0] rem_nx, quot;
  logic q_bit, legal, dz, sdiv;
  // a_q holds the dividend and fills with quotient bits from the bottom as it shifts out
  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .rem_i    (rem_q),
    .bit_i    (a_q[WIDTH-1]),
    .divisor_i(b_q),
    .rem_o    (rem_nx),
    .q_o      (q_bit)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    rem_d = rem_q;
    acc_d = acc_q;
    rd_d = rd_q;
    neg_d = neg_q;
    result_d = result_q;
    done_d = 1'b0;
    we_d = 1'b0;
    quot = {a_q[WIDTH-2:0], q_bit};
    dz = b_q == '0;
    sdiv = mdu_op_t'(op) == MDU_SDIV;
`ifdef MDU_REM_EN
    legal = 1'b1;
`else
    legal = op_q != MDU_UREM;
`endif
    if (state_q == IDLE && start) begin
      state_d = RUN;
      op_d = mdu_op_t'(op);
      cnt_d = '0;
      rd_d = rd_in;
      neg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
      a_d = (sdiv && op_a[WIDTH-1]) ? -op_a : op_a;
      b_d = (sdiv && op_b[WIDTH-1]) ? -op_b : op_b;
      rem_d = '0;
      acc_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (op_q == MDU_MUL) acc_d = acc_q + (b_q[cnt_q] ? {{WIDTH{1'b0}}, a_q} << cnt_q : '0);
      else begin
        a_d = quot;
        rem_d = rem_nx;
      end
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        done_d = 1'b1;
        we_d = legal;
        result_d = op_q == MDU_MUL ? acc_d[WIDTH-1:0] :
                   (!legal || dz) ? '0 :
                   op_q == MDU_UREM ? rem_nx :
                   (op_q == MDU_SDIV && neg_q) ? -quot : quot;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= MDU_MUL;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      acc_q <= '0;
      rd_q <= '0;
      neg_q <= 1'b0;
      result_q <= '0;
      done_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      rem_q <= rem_d;
      acc_q <= acc_d;
      rd_q <= rd_d;
      neg_q <= neg_d;
      result_q <= result_d;
      done_q <= done_d;
      we_q <= we_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign we_out = we_q;
  assign rd_out = rd_q;
  assign result = result_q;
endmodule
